// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch types: instruction/PC widths, PC increment, fetch tag and
// FIFO entry layouts.
package fetch_queue_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned INS_W = 16;
  localparam logic [PC_W-1:0] PC_STEP       = 16'd2;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = 16'hFFFE;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } fetch_tag_t;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of {ins, pc} with flush; head is read
// straight from registered storage.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fq_entry_t                  pushEntry,
  input  logic                       pop,
  input  logic                       flush,
  output fq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '{default: '0};
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        assert (count != FULL || pop);
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: issues reads to a fixed-latency memory under credit
// control, tracks them in a tag shift register and buffers returns for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH       = 4,
  parameter int unsigned     MEM_LATENCY = 2,
  parameter logic [PC_W-1:0] RESET_PC    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-2:0]   mem_raddr,
  input  logic [INS_W-1:0]  mem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  output logic [INS_W-1:0]  out_ins,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned INF_W = $clog2(MEM_LATENCY+1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned TAG_W = $bits(fetch_tag_t);
  localparam int unsigned SR_W  = MEM_LATENCY * TAG_W;

  logic [PC_W-1:0]              fetchPc;
  fetch_tag_t [MEM_LATENCY-1:0] tagSr;
  logic [MEM_LATENCY-1:0]       tagValid;
  logic [INF_W-1:0]             inflight;
  logic [CNT_W-1:0]             count;
  logic [SUM_W-1:0]             used;
  logic [SUM_W-1:0]             avail;
  logic                         pop;
  logic                         issue;
  fetch_tag_t                   newTag;
  fetch_tag_t                   retTag;
  fq_entry_t                    head;
  fq_entry_t                    retEntry;

  for (genvar g = 0; g < MEM_LATENCY; g++) begin : g_tagValid
    assign tagValid[g] = tagSr[g].valid;
  end

  // Credit counts a slot freed by this cycle's pop, so a full FIFO being
  // drained still issues every cycle.
  always_comb begin
    inflight = INF_W'($countones(tagValid));
    pop      = out_valid && out_ready && !redirect_valid;
    used     = SUM_W'(count) + SUM_W'(inflight);
    avail    = SUM_W'(DEPTH) + SUM_W'(pop);
    issue    = used < avail;
    newTag   = '{valid: issue, pc: fetchPc};
    retTag   = tagSr[MEM_LATENCY-1];
    retEntry = '{ins: mem_rdata, pc: retTag.pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc <= RESET_PC;
      tagSr   <= '0;
    end else if (redirect_valid) begin
      fetchPc <= redirect_pc & PC_ALIGN_MASK;
      tagSr   <= '0;
    end else begin
      tagSr <= (tagSr << TAG_W) | SR_W'(newTag);
      if (issue) fetchPc <= fetchPc + PC_STEP;
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retTag.valid),
    .pushEntry (retEntry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign mem_raddr = fetchPc[PC_W-1:1];
  assign out_valid = count != '0;
  assign out_ins   = head.ins;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: 2-cycle memory model, queue-level reference model
// checked every cycle, plus directed literal expectations.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] memRaddr;
  logic [15:0] memRdata;
  logic [15:0] rd1;
  logic        redirectValid;
  logic [15:0] redirectPc;
  logic        outValid;
  logic [15:0] outIns;
  logic [15:0] outPc;
  logic        outReady;

  int nChecks = 0;
  int nFails  = 0;

  fetch_queue #(
    .DEPTH       (DEPTH),
    .MEM_LATENCY (LAT),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_raddr      (memRaddr),
    .mem_rdata      (memRdata),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (outValid),
    .out_ins        (outIns),
    .out_pc         (outPc),
    .out_ready      (outReady)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [14:0] a);
    return 16'h8000 + {1'b0, a};
  endfunction

  always @(posedge clk) begin
    rd1      <= memWord(memRaddr);
    memRdata <= rd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight reads and buffered entries as queues.
  typedef struct {
    logic [15:0] pc;
    int          issued;
  } flight_t;
  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } ent_t;

  flight_t     flightQ[$];
  ent_t        fifoQ[$];
  logic [15:0] mPc;
  int          mCyc;

  always @(negedge clk) begin
    bit      expValid;
    bit      mPop;
    int      credit;
    flight_t f;
    ent_t    e;
    if (rst) begin
      flightQ.delete();
      fifoQ.delete();
      mPc  = 16'h0000;
      mCyc = 0;
    end else begin
      expValid = fifoQ.size() > 0;
      chk("model out_valid", {31'b0, outValid}, {31'b0, expValid});
      if (expValid) begin
        chk("model out_pc", {16'b0, outPc}, {16'b0, fifoQ[0].pc});
        chk("model out_ins", {16'b0, outIns}, {16'b0, fifoQ[0].ins});
      end
      chk("model mem_raddr", {17'b0, memRaddr}, {17'b0, mPc[15:1]});
      mPop   = expValid && outReady && !redirectValid;
      credit = DEPTH - fifoQ.size() - flightQ.size() + (mPop ? 1 : 0);
      if (redirectValid) begin
        flightQ.delete();
        fifoQ.delete();
        mPc = redirectPc & 16'hFFFE;
      end else begin
        if (mPop) void'(fifoQ.pop_front());
        if (flightQ.size() > 0 && flightQ[0].issued + LAT == mCyc) begin
          f = flightQ.pop_front();
          e.pc  = f.pc;
          e.ins = memWord(f.pc[15:1]);
          fifoQ.push_back(e);
        end
        chk("model fifo bound", {31'b0, fifoQ.size() <= DEPTH}, 32'd1);
        if (credit > 0) begin
          f.pc     = mPc;
          f.issued = mCyc;
          flightQ.push_back(f);
          mPc = mPc + 16'd2;
        end
      end
      mCyc++;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic redirectTo(input logic [15:0] pc);
    redirectValid = 1'b1;
    redirectPc    = pc;
  endtask

  logic [15:0] wrapPc  [4] = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
  logic [15:0] wrapIns [4] = '{16'hFFFE, 16'hFFFF, 16'h8000, 16'h8001};

  // Streams from reset: nothing for LAT+1 cycles, then pc 0,2,4,... each cycle.
  task automatic checkStreamFromReset(input int nCyc, input string tag);
    for (int k = 0; k < nCyc; k++) begin
      @(negedge clk);
      if (k < LAT + 1) begin
        chk({tag, " idle valid"}, {31'b0, outValid}, 32'd0);
      end else begin
        chk({tag, " valid"}, {31'b0, outValid}, 32'd1);
        chk({tag, " pc"}, {16'b0, outPc}, 32'(2 * (k - 3)));
        chk({tag, " ins"}, {16'b0, outIns}, 32'(16'h8000 + k - 3));
      end
      nextCycle();
    end
  endtask

  initial begin
    rst           = 1'b1;
    outReady      = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {31'b0, outValid}, 32'd0);
    chk("reset out_ins", {16'b0, outIns}, 32'd0);
    chk("reset out_pc", {16'b0, outPc}, 32'd0);
    chk("reset mem_raddr", {17'b0, memRaddr}, 32'd0);
    nextCycle();
    rst = 1'b0;
    checkStreamFromReset(8, "stream");

    // Decode stalled from reset: exactly DEPTH words buffered, head held.
    rst      = 1'b1;
    outReady = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= LAT + 1) begin
        chk("stall head valid", {31'b0, outValid}, 32'd1);
        chk("stall head pc", {16'b0, outPc}, 32'h0000);
        chk("stall head ins", {16'b0, outIns}, 32'h8000);
      end
      if (k == 9) chk("stall issue count", {17'b0, memRaddr}, 32'd4);
      nextCycle();
    end
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("resume valid", {31'b0, outValid}, 32'd1);
      chk("resume pc", {16'b0, outPc}, 32'(2 * k));
      nextCycle();
    end

    // Redirect mid-stream with reads in flight and data returning.
    redirectTo(16'h0041);
    @(negedge clk);
    chk("redirect fifo nonempty", {31'b0, outValid}, 32'd1);
    nextCycle();
    redirectValid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) chk("redirect raddr", {17'b0, memRaddr}, 32'h0020);
      if (k < 4) begin
        chk("redirect gap", {31'b0, outValid}, 32'd0);
      end else begin
        chk("redirect valid", {31'b0, outValid}, 32'd1);
        chk("redirect pc", {16'b0, outPc}, 32'(16'h0040 + 2 * (k - 4)));
        chk("redirect ins", {16'b0, outIns}, 32'(16'h8020 + k - 4));
      end
      nextCycle();
    end

    // Back-to-back redirects: the second one restarts the latency and wins.
    redirectTo(16'h0100);
    nextCycle();
    redirectTo(16'h0200);
    @(negedge clk);
    chk("b2b gap", {31'b0, outValid}, 32'd0);
    nextCycle();
    redirectValid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k < 5) begin
        chk("b2b gap", {31'b0, outValid}, 32'd0);
      end else begin
        chk("b2b valid", {31'b0, outValid}, 32'd1);
        chk("b2b pc", {16'b0, outPc}, 32'(16'h0200 + 2 * (k - 5)));
        chk("b2b ins", {16'b0, outIns}, 32'(16'h8100 + k - 5));
      end
      nextCycle();
    end

    // PC wraps from 16'hFFFE to 16'h0000.
    redirectTo(16'hFFFC);
    nextCycle();
    redirectValid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk("wrap pc", {16'b0, outPc}, {16'b0, wrapPc[k-4]});
        chk("wrap ins", {16'b0, outIns}, {16'b0, wrapIns[k-4]});
      end
      nextCycle();
    end

    // Asynchronous reset between edges clears out_valid immediately.
    @(posedge clk);
    #3;
    chk("pre-reset valid", {31'b0, outValid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset valid", {31'b0, outValid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkStreamFromReset(7, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
